// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_unit_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem requests, one-entry output register plus skid, redirects.
// Optional MIPS-style branch delay slot when FETCH_DELAY_SLOT_EN is defined.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  fetch_unit_if.master      imem,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] drop_addr_reg, drop_addr_next;
  logic [ADDR_W-1:0] out_pc_reg, out_pc_next;
  logic [31:0]       out_instr_reg, out_instr_next;
  logic [31:0]       skid_instr_reg, skid_instr_next;
  logic              out_valid_reg, out_valid_next;

  logic              transfer;
  logic              load_fetch;
  logic              load_hold;
  logic [ADDR_W-1:0] redirect_target;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] seq_pc;

  // A request never rises while reset is held, so a late ready is ignored.
  assign imem.imem_req  = (state_reg != HOLD) && !reset;
  assign imem.imem_addr = (state_reg == DROP) ? drop_addr_reg : pc_reg;

  assign transfer        = imem.imem_req && imem.imem_ready;
  assign load_fetch      = (state_reg == FETCH) && transfer && (!out_valid_reg || !stall);
  assign load_hold       = (state_reg == HOLD) && !stall;
  assign redirect_target = redirect_pc & ~ADDR_W'(3);
  assign pc_plus4        = pc_reg + ADDR_W'(4);

`ifdef FETCH_DELAY_SLOT_EN
  logic              pending_reg, pending_next;
  logic [ADDR_W-1:0] pending_target_reg, pending_target_next;

  // The delay-slot word is the next one to advance the PC; it steers to the target.
  assign seq_pc = pending_reg    ? pending_target_reg :
                  redirect_valid ? redirect_target    : pc_plus4;

  always_comb begin
    pending_next        = pending_reg;
    pending_target_next = pending_target_reg;
    if (load_fetch || load_hold) begin
      pending_next = 1'b0;
    end else if (redirect_valid && !pending_reg) begin
      pending_next        = 1'b1;
      pending_target_next = redirect_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg        <= 1'b0;
      pending_target_reg <= '0;
    end else begin
      pending_reg        <= pending_next;
      pending_target_reg <= pending_target_next;
    end
  end
`else
  assign seq_pc = pc_plus4;
`endif

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    drop_addr_next  = drop_addr_reg;
    out_pc_next     = out_pc_reg;
    out_instr_next  = out_instr_reg;
    skid_instr_next = skid_instr_reg;
    out_valid_next  = out_valid_reg;

    if (out_valid_reg && !stall) begin
      out_valid_next = 1'b0;
    end

    case (state_reg)
      FETCH: begin
        if (load_fetch) begin
          out_valid_next = 1'b1;
          out_instr_next = imem.imem_rdata;
          out_pc_next    = pc_reg;
          pc_next        = seq_pc;
        end else if (transfer) begin
          skid_instr_next = imem.imem_rdata;
          state_next      = HOLD;
        end
      end
      HOLD: begin
        if (load_hold) begin
          out_valid_next = 1'b1;
          out_instr_next = skid_instr_reg;
          out_pc_next    = pc_reg;
          pc_next        = seq_pc;
          state_next     = FETCH;
        end
      end
      DROP: begin
        if (transfer) begin
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase

`ifndef FETCH_DELAY_SLOT_EN
    // Redirect wins over stall and over any word arriving this cycle.
    if (redirect_valid) begin
      pc_next         = redirect_target;
      out_valid_next  = 1'b0;
      skid_instr_next = '0;
      drop_addr_next  = imem.imem_addr;
      state_next      = (imem.imem_req && !transfer) ? DROP : FETCH;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      drop_addr_reg  <= RESET_PC;
      out_pc_reg     <= '0;
      out_instr_reg  <= '0;
      skid_instr_reg <= '0;
      out_valid_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      drop_addr_reg  <= drop_addr_next;
      out_pc_reg     <= out_pc_next;
      out_instr_reg  <= out_instr_next;
      skid_instr_reg <= skid_instr_next;
      out_valid_reg  <= out_valid_next;
    end
  end

  assign if_valid    = out_valid_reg;
  assign if_instr    = out_instr_reg;
  assign if_pc       = out_pc_reg;
  assign if_pc_plus4 = out_pc_reg + ADDR_W'(4);

endmodule
